// File: rtl/traceback_column_writer.sv
//------------------------------------------------------------------------------
// Module      : traceback_column_writer
// Description : Packs a column of traceback direction entries into memory
//               words of MEM_WIDTH entries each and writes them to consecutive
//               addresses starting at a per-column base address. A partial
//               final word is padded. Writes use a hold-until-ack handshake.
//               Optional feature macro: TB_PAD_STOP_EN. When it is defined,
//               pad slots are all-ones (stop code). Otherwise they are zero.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef MEM_WIDTH
`define MEM_WIDTH 4
`endif

`ifndef DIRECTION_WIDTH
`define DIRECTION_WIDTH 5
`endif

module traceback_column_writer #(
  parameter int MEM_WIDTH       = `MEM_WIDTH,
  parameter int DIRECTION_WIDTH = `DIRECTION_WIDTH,
  parameter int ADDR_WIDTH      = 10
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   col_start,
  input  logic [ADDR_WIDTH-1:0]                  col_base_addr,
  input  logic                                   dir_valid,
  output logic                                   dir_ready,
  input  logic [DIRECTION_WIDTH-1:0]             dir_data,
  input  logic                                   dir_last,
  output logic                                   mem_wen,
  output logic [ADDR_WIDTH-1:0]                  mem_addr,
  output logic [0:MEM_WIDTH*DIRECTION_WIDTH-1]   mem_wdata,
  input  logic                                   mem_ack,
  output logic                                   col_done
);

  localparam int c_dw     = DIRECTION_WIDTH;
  localparam int c_word_w = MEM_WIDTH * DIRECTION_WIDTH;
  localparam int c_cnt_w  = $clog2(MEM_WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_slot = c_cnt_w'(MEM_WIDTH - 1);

`ifdef TB_PAD_STOP_EN
  localparam logic [c_dw-1:0] c_pad = '1;
`else
  localparam logic [c_dw-1:0] c_pad = '0;
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic [ADDR_WIDTH-1:0] r_base;

  logic                  w_accept;
  logic                  w_complete;
  logic                  w_ack;
  logic [0:c_word_w-1]   w_word;

  // An entry can be taken only while filling and the output register is
  // either empty or being emptied by the memory this very cycle.
  assign dir_ready  = (r_state == S_FILL) && !(mem_wen && !mem_ack);
  assign w_accept   = dir_valid && dir_ready;
  assign w_complete = w_accept && ((r_cnt == c_last_slot) || dir_last);
  assign w_ack      = mem_wen && mem_ack;

  // Slots below the last one keep a holding register; the word seen at the
  // completion edge takes earlier slots from storage, the current slot from
  // dir_data and anything after it as padding.
  for (genvar gi = 0; gi < MEM_WIDTH - 1; gi++) begin : g_fill
    localparam logic [c_cnt_w-1:0] c_idx = c_cnt_w'(gi);
    logic [c_dw-1:0] r_slot;

    // Capture the entry destined for this slot.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_slot <= '0;
      end else if (w_accept && (r_cnt == c_idx)) begin
        r_slot <= dir_data;
      end
    end

    assign w_word[gi*c_dw +: c_dw] = (r_cnt > c_idx)  ? r_slot   :
                                     (r_cnt == c_idx) ? dir_data : c_pad;
  end

  // The last slot is only ever filled at the completion edge itself.
  assign w_word[(MEM_WIDTH-1)*c_dw +: c_dw] = (r_cnt == c_last_slot) ? dir_data : c_pad;

  // Column sequencing, slot counting and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_word_idx <= '0;
      r_base     <= '0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      col_done   <= 1'b0;
    end else begin
      col_done <= 1'b0;

      // Retire the pending write; a coincident completion below reloads it
      // in the same edge so the write request has no gap.
      if (w_ack) begin
        mem_wen <= 1'b0;
      end

      if (w_complete) begin
        mem_wen    <= 1'b1;
        mem_addr   <= r_base + r_word_idx;
        mem_wdata  <= w_word;
        r_word_idx <= r_word_idx + 1'b1;
        r_cnt      <= '0;
      end else if (w_accept) begin
        r_cnt <= r_cnt + 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (col_start) begin
            r_base     <= col_base_addr;
            r_word_idx <= '0;
            r_cnt      <= '0;
            r_state    <= S_FILL;
          end
        end
        S_FILL: begin
          if (w_complete && dir_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (w_ack) begin
            r_state  <= S_IDLE;
            col_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_traceback_column_writer.sv
//------------------------------------------------------------------------------
// Module      : tb_traceback_column_writer
// Description : Directed self-checking bench for traceback_column_writer
//               (MEM_WIDTH=4, DIRECTION_WIDTH=5, ADDR_WIDTH=10).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_traceback_column_writer;

  localparam int MW = 4;
  localparam int DW = 5;
  localparam int AW = 10;

`ifdef TB_PAD_STOP_EN
  localparam logic [DW-1:0] PAD = 5'h1F;
`else
  localparam logic [DW-1:0] PAD = 5'h00;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              col_start;
  logic [AW-1:0]     col_base_addr;
  logic              dir_valid;
  logic              dir_ready;
  logic [DW-1:0]     dir_data;
  logic              dir_last;
  logic              mem_wen;
  logic [AW-1:0]     mem_addr;
  logic [0:MW*DW-1]  mem_wdata;
  logic              mem_ack;
  logic              col_done;

  traceback_column_writer #(
    .MEM_WIDTH       (MW),
    .DIRECTION_WIDTH (DW),
    .ADDR_WIDTH      (AW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .col_start     (col_start),
    .col_base_addr (col_base_addr),
    .dir_valid     (dir_valid),
    .dir_ready     (dir_ready),
    .dir_data      (dir_data),
    .dir_last      (dir_last),
    .mem_wen       (mem_wen),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_ack       (mem_ack),
    .col_done      (col_done)
  );

  always #5 clk = ~clk;

  int n_checks     = 0;
  int n_errors     = 0;
  int cyc          = 0;
  int done_count   = 0;
  int done_cyc     = 0;
  int last_ack_cyc = 0;

  logic [AW-1:0]    wr_addr_q[$];
  logic [MW*DW-1:0] wr_data_q[$];
  logic [AW-1:0]    exp_addr_q[$];
  logic [MW*DW-1:0] exp_data_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write and completion monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_wen && mem_ack) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
      last_ack_cyc = cyc;
    end
    if (col_done) begin
      done_count++;
      done_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW*DW-1:0] pack4(input logic [DW-1:0] a, b, c, d);
    return {a, b, c, d};
  endfunction

  task automatic start_col(input logic [AW-1:0] base);
    wr_addr_q.delete();
    wr_data_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    done_count    = 0;
    col_start     = 1'b1;
    col_base_addr = base;
    @(posedge clk); #1;
    col_start = 1'b0;
  endtask

  task automatic send_entry(input logic [DW-1:0] data, input logic last);
    bit ok;
    ok        = 1'b0;
    dir_valid = 1'b1;
    dir_data  = data;
    dir_last  = last;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (dir_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    check("entry_accept", 32'(ok), 32'd1);
    dir_valid = 1'b0;
    dir_last  = 1'b0;
  endtask

  task automatic expect_write(input logic [AW-1:0] addr, input logic [MW*DW-1:0] data);
    exp_addr_q.push_back(addr);
    exp_data_q.push_back(data);
  endtask

  task automatic finish_col(input bit expect_done);
    repeat (6) @(posedge clk);
    #1;
    check("write_count", 32'(wr_addr_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < exp_addr_q.size(); i++) begin
      if (i < wr_addr_q.size()) begin
        check("write_addr", 32'(wr_addr_q[i]), 32'(exp_addr_q[i]));
        check("write_data", 32'(wr_data_q[i]), 32'(exp_data_q[i]));
      end
    end
    check("col_done_count", 32'(done_count), expect_done ? 32'd1 : 32'd0);
    if (expect_done) check("col_done_timing", 32'(done_cyc), 32'(last_ack_cyc + 1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    col_start     = 1'b0;
    col_base_addr = '0;
    dir_valid     = 1'b0;
    dir_data      = '0;
    dir_last      = 1'b0;
    mem_ack       = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_dir_ready", 32'(dir_ready), 32'd0);
    check("rst_mem_wen", 32'(mem_wen), 32'd0);
    check("rst_col_done", 32'(col_done), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    rst_n   = 1'b1;
    mem_ack = 1'b1;
    @(posedge clk); #1;

    // Two full words, memory always ready
    start_col(10'h010);
    check("fill_ready", 32'(dir_ready), 32'd1);
    for (int v = 1; v <= 8; v++) send_entry(DW'(v), v == 8);
    expect_write(10'h010, pack4(5'd1, 5'd2, 5'd3, 5'd4));
    expect_write(10'h011, pack4(5'd5, 5'd6, 5'd7, 5'd8));
    finish_col(1'b1);

    // Partial last word padded; its completion coincides with the first ack
    start_col(10'h020);
    for (int v = 1; v <= 5; v++) send_entry(DW'(v), v == 5);
    check("nogap_wen", 32'(mem_wen), 32'd1);
    check("nogap_addr", 32'(mem_addr), 32'h021);
    check("drain_ready", 32'(dir_ready), 32'd0);
    expect_write(10'h020, pack4(5'd1, 5'd2, 5'd3, 5'd4));
    expect_write(10'h021, pack4(5'd5, PAD, PAD, PAD));
    finish_col(1'b1);

    // Backpressure: ack held low six cycles with a full word pending
    mem_ack = 1'b0;
    start_col(10'h040);
    for (int v = 1; v <= 4; v++) send_entry(DW'(v), 1'b0);
    dir_valid = 1'b1;
    dir_data  = 5'd5;
    dir_last  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("stall_ready", 32'(dir_ready), 32'd0);
      check("stall_wen", 32'(mem_wen), 32'd1);
      check("stall_addr", 32'(mem_addr), 32'h040);
      check("stall_data", 32'(mem_wdata), 32'(pack4(5'd1, 5'd2, 5'd3, 5'd4)));
      @(posedge clk); #1;
    end
    mem_ack = 1'b1;
    for (int v = 5; v <= 8; v++) send_entry(DW'(v), v == 8);
    expect_write(10'h040, pack4(5'd1, 5'd2, 5'd3, 5'd4));
    expect_write(10'h041, pack4(5'd5, 5'd6, 5'd7, 5'd8));
    finish_col(1'b1);

    // Address wrap, with a stray col_start during FILL
    start_col(10'h3FF);
    send_entry(5'd1, 1'b0);
    send_entry(5'd2, 1'b0);
    col_start     = 1'b1;
    col_base_addr = 10'h123;
    @(posedge clk); #1;
    col_start = 1'b0;
    for (int v = 3; v <= 8; v++) send_entry(DW'(v), v == 8);
    expect_write(10'h3FF, pack4(5'd1, 5'd2, 5'd3, 5'd4));
    expect_write(10'h000, pack4(5'd5, 5'd6, 5'd7, 5'd8));
    finish_col(1'b1);

    // Asynchronous reset mid-column
    start_col(10'h050);
    send_entry(5'd1, 1'b0);
    send_entry(5'd2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(dir_ready), 32'd0);
    check("mid_rst_wen", 32'(mem_wen), 32'd0);
    check("mid_rst_done", 32'(col_done), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", 32'(mem_wdata), 32'd0);
    dir_valid = 1'b1;
    dir_data  = 5'd3;
    dir_last  = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("post_rst_wen", 32'(mem_wen), 32'd0);
      check("post_rst_ready", 32'(dir_ready), 32'd0);
      @(posedge clk); #1;
    end
    dir_valid = 1'b0;
    finish_col(1'b0);

    // Single entry column
    start_col(10'h070);
    send_entry(5'd7, 1'b1);
    expect_write(10'h070, pack4(5'd7, PAD, PAD, PAD));
    finish_col(1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traceback_column_writer.md
TRACEBACK_COLUMN_WRITER -- requirements
Module: traceback_column_writer

Interface
REQ-001 SHALL have parameter MEM_WIDTH, default `MEM_WIDTH, giving entries per memory word (power of two, >=2).
REQ-002 SHALL have parameter DIRECTION_WIDTH, default `DIRECTION_WIDTH (5), giving bits per direction entry.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, giving the traceback memory address width.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port col_start  input  1  pulse that begins a new column; sampled only in IDLE.
REQ-007 SHALL have port col_base_addr  input  ADDR_WIDTH  first word address of the column; latched on accepted col_start.
REQ-008 SHALL have port dir_valid  input  1  direction entry offered.
REQ-009 SHALL have port dir_ready  output  1  entry accepted when dir_valid and dir_ready are both high.
REQ-010 SHALL have port dir_data  input  DIRECTION_WIDTH  direction entry, in ascending x order.
REQ-011 SHALL have port dir_last  input  1  qualifies dir_data as the final entry of the column.
REQ-012 SHALL have port mem_wen  output  1  write request.
REQ-013 SHALL have port mem_addr  output  ADDR_WIDTH  write address.
REQ-014 SHALL have port mem_wdata  output  [0:MEM_WIDTH*DIRECTION_WIDTH-1]  packed column word, ascending-numbered.
REQ-015 SHALL have port mem_ack  input  1  memory accepted the write this cycle.
REQ-016 SHALL have port col_done  output  1  one-cycle pulse, column fully written.

Function
REQ-017 SHALL implement states IDLE, FILL, DRAIN.
REQ-018 SHALL, in IDLE, accept col_start -> latch base, clear word index and slot count, enter FILL next cycle.
REQ-019 SHALL drive dir_ready = (state==FILL) and not (out_valid and not mem_ack).
REQ-020 SHALL write accepted entry into slot cnt; slot i occupies mem_wdata bits [i*DW .. i*DW+DW-1], bit i*DW being the entry MSB.
REQ-021 SHALL complete a word when the accepted entry has cnt==MEM_WIDTH-1 or dir_last=1; the word moves to the output register at that edge, cnt returns to 0, word index increments.
REQ-022 SHALL, on a word completed by dir_last with cnt<MEM_WIDTH-1, fill slots cnt+1..MEM_WIDTH-1 with the pad value (REQ-032).
REQ-023 SHALL assert mem_wen the cycle after word completion; mem_wen, mem_addr and mem_wdata are held stable until the cycle mem_ack is high.
REQ-024 SHALL set mem_addr = col_base_addr + word index, modulo 2^ADDR_WIDTH (wrap allowed).
REQ-025 SHALL, when mem_ack and a new word completion coincide, load the new word into the output register so that mem_wen stays high without a gap.
REQ-026 SHALL enter DRAIN after the dir_last word completes; in DRAIN dir_ready=0.
REQ-027 SHALL, in DRAIN, on mem_ack return to IDLE and pulse col_done for exactly one cycle (the first IDLE cycle); col_start in that cycle is accepted.
REQ-028 SHALL ignore col_start outside IDLE; ignore mem_ack while mem_wen=0.

Reset
REQ-029 SHALL, on rst_n low, immediately force state IDLE, dir_ready=0, mem_wen=0, col_done=0, mem_addr=0, mem_wdata=0, cnt=0, word index=0.
REQ-030 SHALL discard any partial or pending word when reset asserts mid-column; no write issues after release until a new col_start.

Configuration
REQ-031 SHALL support macro TB_PAD_STOP_EN.
REQ-032 SHALL pad unused slots with all-ones (stop code) when TB_PAD_STOP_EN is defined, and with all-zeros when it is not.

Verification (MEM_WIDTH=4, DW=5, ADDR_WIDTH=10)
REQ-033 SHALL cover: col_start base=0x010, 8 entries 1..8, last on 8, mem_ack always high -> writes {1,2,3,4}@0x010, {5,6,7,8}@0x011, col_done one cycle after second ack.
REQ-034 SHALL cover: base=0x020, 5 entries 1..5, last on 5 -> second word {5,pad,pad,pad}@0x021; pad=0x1F with TB_PAD_STOP_EN, 0x00 without.
REQ-035 SHALL cover: mem_ack held low 6 cycles with full word pending -> dir_ready=0, mem_wen/addr/data unchanged for 6 cycles, no entry lost.
REQ-036 SHALL cover: base=0x3FF, 8 entries -> addresses 0x3FF then 0x000.
REQ-037 SHALL cover: rst_n low after 2 of 4 entries -> all outputs 0 at once; after release no mem_wen until col_start.
REQ-038 SHALL cover: single entry 7 with dir_last directly after col_start -> one write {7,pad,pad,pad}, then col_done.
